dmem_store_unit: RTL and testbench



---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_store_unit_if.sv | 16 +
 rtl/dmem_lane_mux.sv | 10 +
 rtl/dmem_store_unit.sv | 65 ++++++
 tb/tb_dmem_store_unit.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared word/lane layout for the data-memory read and write paths.
package dmem_pkg;
    localparam int DATA_W = 32;
    localparam int LANES  = 6;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;
    localparam int VEC_W  = LANES * DATA_W;
    localparam int CNT_W  = $clog2(LANES + 1);
    typedef enum logic {ST_IDLE, ST_WRITE} st_e;
    // Out-of-range lane indices read as zero rather than X.
    function automatic logic [DATA_W-1:0] lane_sel(input logic [VEC_W-1:0] v, input logic [CNT_W-1:0] i);
        return (i < CNT_W'(LANES)) ? v[i*DATA_W +: DATA_W] : '0;
    endfunction
endpackage

// File: rtl/dmem_store_unit_if.sv
// dmem_store_unit_if: store-request handshake plus the one-word RAM write port.
interface dmem_store_unit_if;
    import dmem_pkg::*;
    logic              req_valid;
    logic              req_ready;
    logic              isVector;
    logic [ADDR_W-1:0] address;
    logic [VEC_W-1:0]  wd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic              done;
    logic              err;
    modport master (output req_valid, isVector, address, wd, input req_ready, mem_we, mem_addr, mem_wd, done, err);
    modport slave  (input req_valid, isVector, address, wd, output req_ready, mem_we, mem_addr, mem_wd, done, err);
endinterface

// File: rtl/dmem_lane_mux.sv
// dmem_lane_mux: picks lane sel out of the captured store vector.
module dmem_lane_mux
    import dmem_pkg::*;
(
    input  logic [VEC_W-1:0]  vec,
    input  logic [CNT_W-1:0]  sel,
    output logic [DATA_W-1:0] lane
);
    assign lane = lane_sel(vec, sel);
endmodule

// File: rtl/dmem_store_unit.sv
// dmem_store_unit: serializes scalar/vector stores into one-word RAM writes,
// rejecting requests whose last word falls outside the RAM.
module dmem_store_unit
    import dmem_pkg::*;
(
    input logic         clk,
    input logic         rst,
    dmem_store_unit_if.slave bus
);
    st_e               state;
    logic [VEC_W-1:0]  vec;
    logic [CNT_W-1:0]  k, n, n_req;
    logic [DATA_W-1:0] lane;
    logic [ADDR_W:0]   last;
    logic              accept;

    assign bus.req_ready = rst && state == ST_IDLE;
    assign accept        = bus.req_valid && bus.req_ready;
    assign n_req         = bus.isVector ? CNT_W'(LANES) : CNT_W'(1);
    // One extra bit so addresses near the top cannot wrap back into range.
    assign last          = {1'b0, bus.address} + (ADDR_W+1)'(bus.isVector ? LANES - 1 : 0);

    dmem_lane_mux u_mux (.vec(vec), .sel(k), .lane(lane));

    // Lane 0 is written straight from the request; later lanes come from vec.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            vec          <= '0;
            k            <= '0;
            n            <= '0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wd   <= '0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
        end else if (state == ST_IDLE) begin
            bus.mem_we <= 1'b0;
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
            if (accept && last >= (ADDR_W+1)'(DEPTH)) begin
                bus.err <= 1'b1;
            end else if (accept) begin
                state        <= ST_WRITE;
                vec          <= bus.wd;
                n            <= n_req;
                k            <= CNT_W'(1);
                bus.mem_we   <= 1'b1;
                bus.mem_addr <= bus.address;
                bus.mem_wd   <= bus.wd[DATA_W-1:0];
                bus.done     <= !bus.isVector;
            end
        end else if (k == n) begin
            state      <= ST_IDLE;
            k          <= '0;
            bus.mem_we <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            k            <= k + CNT_W'(1);
            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
            bus.mem_wd   <= lane;
            bus.done     <= k == n - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_dmem_store_unit.sv
// tb_dmem_store_unit: directed and random stores checked cycle-by-cycle and
// against a word-addressed RAM image built from the store rules.
module tb_dmem_store_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] model_ram [256];
    logic [31:0] dut_ram [256];
    logic        cur_v;
    logic [31:0] cur_a;
    logic [191:0] cur_d;
    int          waited;

    dmem_store_unit_if ifc ();
    dmem_store_unit dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ifc.mem_we === 1'b1 && ifc.mem_addr < 32'd256) dut_ram[ifc.mem_addr[7:0]] <= ifc.mem_wd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] rnd_vec();
        logic [191:0] r;
        for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Called at a negedge; waits (bounded) for ready, then lets the next edge accept.
    task automatic start(input logic v, input logic [31:0] a, input logic [191:0] d, input logic keep);
        ifc.isVector = v; ifc.address = a; ifc.wd = d; ifc.req_valid = 1'b1;
        waited = 0;
        while (ifc.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_timeout", 64'(waited < 20), 64'd1);
        @(posedge clk);
        #1;
        cur_v = v; cur_a = a; cur_d = d;
        if (!keep) begin
            ifc.req_valid = 1'b0; ifc.isVector = $urandom; ifc.address = $urandom; ifc.wd = rnd_vec();
        end
    endtask

    // Checks every cycle after acceptance until the unit is idle again; ends at a negedge.
    task automatic check_burst();
        int nw = cur_v ? 6 : 1;
        logic legal = ({32'd0, cur_a} + 64'(nw) - 64'd1) < 64'd256;
        if (!legal) begin
            @(negedge clk);
            chk("err_pulse", 64'(ifc.err), 64'd1);
            chk("err_no_we", 64'(ifc.mem_we), 64'd0);
            chk("err_no_done", 64'(ifc.done), 64'd0);
            chk("err_ready", 64'(ifc.req_ready), 64'd1);
            @(negedge clk);
            chk("err_clear", 64'(ifc.err), 64'd0);
            chk("err_no_we2", 64'(ifc.mem_we), 64'd0);
        end else begin
            for (int k = 0; k < nw; k++) begin
                @(negedge clk);
                chk("we", 64'(ifc.mem_we), 64'd1);
                chk("addr", 64'(ifc.mem_addr), 64'(cur_a + 32'(k)));
                chk("data", 64'(ifc.mem_wd), 64'(cur_d[k*32 +: 32]));
                chk("done", 64'(ifc.done), 64'(k == nw - 1));
                chk("no_err", 64'(ifc.err), 64'd0);
                chk("busy", 64'(ifc.req_ready), 64'd0);
                model_ram[cur_a[7:0] + 8'(k)] = cur_d[k*32 +: 32];
            end
            @(negedge clk);
            chk("idle_we", 64'(ifc.mem_we), 64'd0);
            chk("idle_done", 64'(ifc.done), 64'd0);
            chk("idle_ready", 64'(ifc.req_ready), 64'd1);
        end
    endtask

    initial begin
        logic [191:0] d;
        logic [31:0]  a;
        for (int i = 0; i < 256; i++) begin model_ram[i] = '0; dut_ram[i] = '0; end
        rst = 1'b0; ifc.req_valid = 1'b0; ifc.isVector = 1'b0; ifc.address = '0; ifc.wd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 64'(ifc.mem_we), 64'd0);
        chk("rst_addr", 64'(ifc.mem_addr), 64'd0);
        chk("rst_wd", 64'(ifc.mem_wd), 64'd0);
        chk("rst_done", 64'(ifc.done), 64'd0);
        chk("rst_err", 64'(ifc.err), 64'd0);
        chk("rst_ready", 64'(ifc.req_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(ifc.req_ready), 64'd1);

        d = rnd_vec(); d[31:0] = 32'hDEADBEEF;
        start(1'b0, 32'd1, d, 1'b0); check_burst();
        d = {32'h66666666, 32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        start(1'b1, 32'd2, d, 1'b0); check_burst();
        start(1'b1, 32'd250, rnd_vec(), 1'b0); check_burst();
        start(1'b1, 32'd251, rnd_vec(), 1'b0); check_burst();
        start(1'b0, 32'd255, rnd_vec(), 1'b0); check_burst();
        start(1'b0, 32'hFFFFFFFF, rnd_vec(), 1'b0); check_burst();
        start(1'b0, 32'd3, rnd_vec(), 1'b0); check_burst();

        // Back-to-back: valid stays high; the second request lands right after idle.
        start(1'b1, 32'd10, rnd_vec(), 1'b1);
        d = rnd_vec();
        ifc.address = 32'd40; ifc.wd = d;
        check_burst();
        start(1'b1, 32'd40, d, 1'b0);
        chk("b2b_no_wait", 64'(waited), 64'd0);
        check_burst();

        // Reset during the third lane write of a vector store.
        d = rnd_vec();
        start(1'b1, 32'd100, d, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rb_we", 64'(ifc.mem_we), 64'd1);
            chk("rb_addr", 64'(ifc.mem_addr), 64'(32'd100 + 32'(k)));
            chk("rb_data", 64'(ifc.mem_wd), 64'(d[k*32 +: 32]));
            model_ram[8'd100 + 8'(k)] = d[k*32 +: 32];
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rb_we_off", 64'(ifc.mem_we), 64'd0);
        chk("rb_done_off", 64'(ifc.done), 64'd0);
        chk("rb_err_off", 64'(ifc.err), 64'd0);
        chk("rb_ready_rst", 64'(ifc.req_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rb_ready_rel", 64'(ifc.req_ready), 64'd1);
        chk("rb_we_rel", 64'(ifc.mem_we), 64'd0);
        start(1'b0, 32'd120, rnd_vec(), 1'b0); check_burst();

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                1, 2:    a = 32'd245 + 32'($urandom_range(0, 15));
                default: a = 32'($urandom_range(0, 255));
            endcase
            start(1'($urandom), a, rnd_vec(), 1'b0);
            check_burst();
        end

        for (int i = 0; i < 256; i++) chk($sformatf("ram[%0d]", i), 64'(dut_ram[i]), 64'(model_ram[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
